rsa_mont_mul: RTL and testbench



---
 rtl/rsa_mont_mul.sv | 122 ++++++++++++
 tb/tb_rsa_mont_mul.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery multiplier: o_m = i_a * i_b * 2^(-bitwidth) mod i_n.
// One radix-2 iteration per clock over the bits of a, then one final-reduction cycle.
module rsa_mont_mul #(
    parameter int bitwidth = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [bitwidth-1:0] i_a,
    input  logic [bitwidth-1:0] i_b,
    input  logic [bitwidth-1:0] i_n,
    output logic [bitwidth-1:0] o_m,
    output logic                o_finished
);

    localparam int CNT_W = $clog2(bitwidth);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [bitwidth-1:0] a_reg;
    logic [bitwidth-1:0] b_reg;
    logic [bitwidth-1:0] n_reg;
    logic [bitwidth+1:0] m_acc;
    logic [bitwidth+1:0] m_next;
    logic                load;
    logic                iterate;
    logic                finish;
    logic                last_iter;

    // Two guard bits keep m + b + n below 4n, so no carry is lost while m < 2n.
    function automatic logic [bitwidth+1:0] mont_step(
        input logic [bitwidth+1:0] acc,
        input logic                a_bit,
        input logic [bitwidth-1:0] b,
        input logic [bitwidth-1:0] n
    );
        logic [bitwidth+1:0] t;
        t = acc + (a_bit ? {2'b00, b} : '0);
        if (t[0])
            t = t + {2'b00, n};
        return t >> 1;
    endfunction

    function automatic logic [bitwidth-1:0] final_reduce(
        input logic [bitwidth+1:0] acc,
        input logic [bitwidth-1:0] n
    );
        logic [bitwidth+1:0] ext_n;
        ext_n = {2'b00, n};
        if (acc >= ext_n)
            return bitwidth'(acc - ext_n);
        else
            return bitwidth'(acc);
    endfunction

    assign last_iter = (cnt == CNT_W'(bitwidth - 1));
    assign m_next    = mont_step(m_acc, a_reg[cnt], b_reg, n_reg);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        iterate = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE:    load    = i_start;
            CALC:    iterate = 1'b1;
            DONE:    finish  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            n_reg      <= '0;
            m_acc      <= '0;
            cnt        <= '0;
            o_m        <= '0;
            o_finished <= 1'b0;
        end else begin
            o_finished <= finish;
            if (load) begin
                a_reg <= i_a;
                b_reg <= i_b;
                n_reg <= i_n;
                m_acc <= '0;
                cnt   <= '0;
            end else if (iterate) begin
                m_acc <= m_next;
                if (!last_iter)
                    cnt <= cnt + 1'b1;
            end
            if (finish)
                o_m <= final_reduce(m_acc, n_reg);
        end
    end

endmodule

// File: tb/tb_rsa_mont_mul.sv
// Directed bench for rsa_mont_mul: an 8-bit and a 256-bit instance share clock and reset.
module tb_rsa_mont_mul;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0, n8 = '0;
    logic [7:0]   om8;
    logic         fin8;
    logic         start256 = 1'b0;
    logic [255:0] a256 = '0, b256 = '0, n256 = '0;
    logic [255:0] om256;
    logic         fin256;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rsa_mont_mul #(.bitwidth(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
        .i_a(a8), .i_b(b8), .i_n(n8),
        .o_m(om8), .o_finished(fin8)
    );

    rsa_mont_mul #(.bitwidth(256)) dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start256),
        .i_a(a256), .i_b(b256), .i_n(n256),
        .o_m(om256), .o_finished(fin256)
    );

    // Independent model: reduce the full product first, then halve mod n 256 times.
    function automatic logic [255:0] golden(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n);
        logic [511:0] p;
        logic [256:0] x;
        p = (512'(a) * 512'(b)) % 512'(n);
        x = 257'(p);
        for (int k = 0; k < 256; k++) begin
            if (x[0]) x = (x + {1'b0, n}) >> 1;
            else      x = x >> 1;
        end
        return x[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drivers only: return the result and the cycle (negedges after the start edge) it arrived.
    task automatic job8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                        output logic [7:0] m, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; n8 = n; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1;
        m = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (fin8) begin
                lat = c;
                m = om8;
                break;
            end
        end
    endtask

    task automatic job256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                          output logic [255:0] m, output int lat);
        @(negedge clk);
        a256 = a; b256 = b; n256 = n; start256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0;
        lat = -1;
        m = 'x;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (fin256) begin
                lat = c;
                m = om256;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (om8 !== 8'd0) begin n_fail++; $display("FAIL reset_om8 got=%0d exp=0", om8); end
        n_cmp++; if (fin8 !== 1'b0) begin n_fail++; $display("FAIL reset_fin8 got=%b exp=0", fin8); end
        n_cmp++; if (om256 !== 256'd0) begin n_fail++; $display("FAIL reset_om256 got=%h exp=0", om256); end
        n_cmp++; if (fin256 !== 1'b0) begin n_fail++; $display("FAIL reset_fin256 got=%b exp=0", fin256); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] m;
        int lat;
        job8(8'd5, 8'd7, 8'd13, m, lat);
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        n_cmp++; if (m !== 8'd1) begin n_fail++; $display("FAIL basic_result got=%0d exp=1", m); end
        @(negedge clk);
        n_cmp++; if (fin8 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got=%b exp=0", fin8); end
        n_cmp++; if (om8 !== 8'd1) begin n_fail++; $display("FAIL basic_hold got=%0d exp=1", om8); end
    endtask

    task automatic test_overflow();
        logic [7:0] m;
        int lat;
        job8(8'd254, 8'd254, 8'd255, m, lat);
        n_cmp++; if (m !== 8'd1) begin n_fail++; $display("FAIL ovf_max_result got=%0d exp=1", m); end
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL ovf_max_latency got=%0d exp=9", lat); end
        job8(8'd0, 8'd200, 8'd255, m, lat);
        n_cmp++; if (m !== 8'd0) begin n_fail++; $display("FAIL ovf_zero_result got=%0d exp=0", m); end
    endtask

    task automatic test_random();
        logic [255:0] a, b, n, m, exp;
        int lat;
        for (int k = 0; k < 200; k++) begin
            n = rand256();
            n[0] = 1'b1;
            n[255] = 1'b1;
            a = rand256() % n;
            b = rand256() % n;
            exp = golden(a, b, n);
            job256(a, b, n, m, lat);
            n_cmp++;
            if (m !== exp || lat !== 257) begin
                n_fail++;
                $display("FAIL random_%0d got=%h lat=%0d exp=%h lat=257", k, m, lat, exp);
            end
        end
    endtask

    task automatic test_wide();
        logic [255:0] n, m;
        int lat;
        n = {256{1'b1}} - 256'd188;
        job256(256'd189, 256'd12345, n, m, lat);
        n_cmp++; if (lat !== 257) begin n_fail++; $display("FAIL wide_latency got=%0d exp=257", lat); end
        n_cmp++; if (m !== 256'd12345) begin n_fail++; $display("FAIL wide_result got=%h exp=12345", m); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int c1 = -1, c2 = -1;
        logic [7:0] m1 = 'x, m2 = 'x;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; n8 = 8'd13; start8 = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (fin8) begin
                pulses++;
                if (c1 < 0) begin c1 = c; m1 = om8; end
                else begin c2 = c; m2 = om8; end
            end
            if (c == 3) begin a8 = 8'd7; n8 = 8'd11; end
            if (c == 9) begin a8 = 8'd12; b8 = 8'd12; n8 = 8'd13; end
            if (c == 10) start8 = 1'b0;
            if (c == 14) begin a8 = 8'd3; b8 = 8'd0; n8 = 8'd5; end
        end
        n_cmp++; if (c1 !== 9) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=9", c1); end
        n_cmp++; if (m1 !== 8'd3) begin n_fail++; $display("FAIL b2b_first_result got=%0d exp=3", m1); end
        n_cmp++; if (c2 !== 19) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=19", c2); end
        n_cmp++; if (m2 !== 8'd3) begin n_fail++; $display("FAIL b2b_second_result got=%0d exp=3", m2); end
        n_cmp++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        int lat;
        int stray = 0;
        @(negedge clk);
        a256 = 256'd5; b256 = 256'd7; n256 = 256'd13; start256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_cmp++; if (om256 !== 256'd12345) begin n_fail++; $display("FAIL midrst_hold256 got=%h exp=12345", om256); end
        n_cmp++; if (om8 !== 8'd3) begin n_fail++; $display("FAIL midrst_hold8 got=%0d exp=3", om8); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (om256 !== 256'd0) begin n_fail++; $display("FAIL midrst_om256 got=%h exp=0", om256); end
        n_cmp++; if (fin256 !== 1'b0) begin n_fail++; $display("FAIL midrst_fin256 got=%b exp=0", fin256); end
        n_cmp++; if (om8 !== 8'd0) begin n_fail++; $display("FAIL midrst_om8 got=%0d exp=0", om8); end
        @(negedge clk);
        rst_n = 1'b1;
        job8(8'd1, 8'd1, 8'd13, m, lat);
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL postrst_latency got=%0d exp=9", lat); end
        n_cmp++; if (m !== 8'd3) begin n_fail++; $display("FAIL postrst_result got=%0d exp=3", m); end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (fin256) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL midrst_no_pulse got=%0d exp=0", stray); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
